checker_auto_seq: RTL and testbench
===================================

// Module: checker_auto_seq
// PURPOSE
//  Sequencer for CHECKER_MODE_AUTO. Sits between the checker CSR control interface (mode_* side)
//  and a single-page checker engine (pg_* side). Walks mode_count consecutive pages from
//  mode_addr, starting the engine on one page at a time. Reports end, error and progress back
//  on the mode_* handshake.
// PARAMETERS
//  PAGE_SHIFT  12  log2 page size; page stride = 1<<PAGE_SHIFT bytes
//  GAP_CYCLES  1   idle cycles (pg_start low) between pages, >=1
// PORTS
//  sys_clk     in   1   clock
//  sys_rst     in   1   synchronous, active-high reset
//  mode_start  in   1   level; rise in IDLE = go, drop = user abort
//  mode_addr   in   64  base address, sampled at go
//  mode_count  in   32  number of pages, sampled at go
//  mode_end    out  1   one-cycle pulse: all pages checked
//  mode_error  out  1   one-cycle pulse: engine error or address wrap
//  mode_irq    out  1   engine irq relay
//  mode_ack    in   1   irq ack from control interface
//  mode_data   out  64  {pages_done[31:0], count_latched[31:0]}
//  pg_start    out  1   engine start, level
//  pg_addr     out  64  current page address, page aligned
//  pg_end      in   1   engine page done, one-cycle pulse
//  pg_error    in   1   engine error, one-cycle pulse
//  pg_irq      in   1   engine irq, level until acked
//  pg_ack      out  1   ack to engine
// BEHAVIOUR
//  Reset
//   - All outputs 0; pages_done=0, count_latched=0; state IDLE.
//   - Reset mid-run drops pg_start the next edge, with no end/error pulse.
//  States
//   - IDLE, ISSUE, RUN, GAP, HOLD. All outputs are registered except mode_irq and pg_ack.
//  IDLE
//   - Condition: mode_start=1.
//   - Action: latch cur = mode_addr with [PAGE_SHIFT-1:0] cleared, count_latched = mode_count,
//     pages_done = 0.
//   - If mode_count=0: pulse mode_end, go to HOLD.
//   - Otherwise go to ISSUE.
//  ISSUE
//   - pg_addr <= cur; pg_start <= 1; go to RUN.
//   - pg_start rises 2 cycles after mode_start is first seen high.
//  RUN (priority order, one event acted on per cycle)
//   1. mode_start=0 (abort): pg_start <= 0; go to IDLE; no pulse.
//   2. pg_error: pg_start <= 0; pulse mode_error; go to HOLD; pages_done unchanged.
//   3. pg_end: pg_start <= 0; pages_done += 1.
//      - If pages_done+1 == count_latched: pulse mode_end; go to HOLD.
//      - Else if cur + stride carries out of bit 63: pulse mode_error; go to HOLD.
//      - Else cur += stride; go to GAP.
//  GAP
//   - Wait GAP_CYCLES cycles, then go to ISSUE.
//   - mode_start=0 goes to IDLE.
//  HOLD
//   - Wait for mode_start=0, then go to IDLE. Prevents retrigger.
//   - mode_data stays frozen until the next go.
//  IRQ relay
//   - mode_irq = pg_irq & (state==RUN).
//   - pg_ack = mode_ack & (state==RUN).
//   - Combinational; the sequencer does not advance on irq.
//  Widths
//   - pages_done is 32b and never exceeds count_latched.
//   - Address arithmetic is 64b; the carry out is the wrap detect.
//  Simultaneous events
//   - pg_end and pg_error in the same cycle: treated as error.
//   - Abort in the same cycle as pg_end: abort wins, pages_done not incremented.
// TESTING
//  T1 3 pages
//   - Stimulus: addr=0x0000_0000_1000_0123, count=3, PAGE_SHIFT=12.
//   - Required: pg_addr 0x10000000, 0x10001000, 0x10002000; pg_start low >= 1 cycle between
//     pages; one mode_end; mode_data=0x00000003_00000003.
//  T2 Error on the 2nd page
//   - Stimulus: pg_error on the 2nd page.
//   - Required: mode_error pulse; no mode_end; mode_data[63:32]=1; pg_start low next cycle.
//  T3 Abort
//   - Stimulus: mode_start dropped during the 2nd page RUN.
//   - Required: pg_start low next cycle; no pulses; state IDLE; a new go restarts from base.
//  T4 count=0
//   - Required: mode_end pulse; pg_start never asserted.
//  T5 Address wrap
//   - Stimulus: addr=0xFFFF_FFFF_FFFF_F000, count=2.
//   - Required: page 1 completes, then mode_error; mode_data[63:32]=1.
//  T6 IRQ and reset
//   - IRQ: pg_irq held in RUN -> mode_irq high; mode_ack -> pg_ack same cycle.
//   - Reset: sys_rst mid-RUN -> all outputs 0 next edge.

Source files
------------

// File: rtl/checker_auto_seq.sv
// checker_auto_seq: auto-mode page sequencer. Walks mode_count consecutive
// pages starting at the page-aligned mode_addr. The engine is started on one
// page at a time. End, error and progress are reported on the mode_* side.
module checker_auto_seq #(
  parameter int PAGE_SHIFT = 12,
  parameter int GAP_CYCLES = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        mode_start,
  input  logic [63:0] mode_addr,
  input  logic [31:0] mode_count,
  output logic        mode_end,
  output logic        mode_error,
  output logic        mode_irq,
  input  logic        mode_ack,
  output logic [63:0] mode_data,
  output logic        pg_start,
  output logic [63:0] pg_addr,
  input  logic        pg_end,
  input  logic        pg_error,
  input  logic        pg_irq,
  output logic        pg_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_GAP,
    S_HOLD
  } state_t;

  localparam logic [63:0] STRIDE    = 64'd1 << PAGE_SHIFT;
  localparam logic [63:0] PAGE_MASK = ~(STRIDE - 64'd1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  state_t      state, state_nx;
  logic [63:0] cur, cur_nx;
  logic [31:0] count_latched, count_nx;
  logic [31:0] pages_done, done_nx;
  logic [31:0] gap_cnt, gap_nx;
  logic        pg_start_nx, end_nx, error_nx;
  logic [63:0] pg_addr_nx;

  logic [64:0] cur_inc;
  logic [31:0] done_inc;

  // The 65th bit of the page step is the address wrap detect
  assign cur_inc  = {1'b0, cur} + {1'b0, STRIDE};
  assign done_inc = pages_done + 32'd1;

  // Progress word is built directly from the registered counters
  assign mode_data = {pages_done, count_latched};

  // The irq relay is only open while a page is actually running
  assign mode_irq = pg_irq & (state == S_RUN);
  assign pg_ack   = mode_ack & (state == S_RUN);

  // Next-state and next-register values; abort beats error beats page end
  always_comb begin
    state_nx    = state;
    cur_nx      = cur;
    count_nx    = count_latched;
    done_nx     = pages_done;
    gap_nx      = gap_cnt;
    pg_start_nx = pg_start;
    pg_addr_nx  = pg_addr;
    end_nx      = 1'b0;
    error_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (mode_start) begin
          cur_nx   = mode_addr & PAGE_MASK;
          count_nx = mode_count;
          done_nx  = 32'd0;
          gap_nx   = 32'd0;
          if (mode_count == 32'd0) begin
            end_nx   = 1'b1;
            state_nx = S_HOLD;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        pg_addr_nx  = cur;
        pg_start_nx = 1'b1;
        state_nx    = S_RUN;
      end
      S_RUN: begin
        if (!mode_start) begin
          pg_start_nx = 1'b0;
          state_nx    = S_IDLE;
        end else if (pg_error) begin
          pg_start_nx = 1'b0;
          error_nx    = 1'b1;
          state_nx    = S_HOLD;
        end else if (pg_end) begin
          pg_start_nx = 1'b0;
          done_nx     = done_inc;
          if (done_inc == count_latched) begin
            end_nx   = 1'b1;
            state_nx = S_HOLD;
          end else if (cur_inc[64]) begin
            error_nx = 1'b1;
            state_nx = S_HOLD;
          end else begin
            cur_nx   = cur_inc[63:0];
            gap_nx   = 32'd0;
            state_nx = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (!mode_start) begin
          state_nx = S_IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          state_nx = S_ISSUE;
        end else begin
          gap_nx = gap_cnt + 32'd1;
        end
      end
      S_HOLD: begin
        if (!mode_start) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx    = S_IDLE;
        pg_start_nx = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      cur           <= 64'd0;
      count_latched <= 32'd0;
      pages_done    <= 32'd0;
      gap_cnt       <= 32'd0;
      pg_start      <= 1'b0;
      pg_addr       <= 64'd0;
      mode_end      <= 1'b0;
      mode_error    <= 1'b0;
    end else begin
      state         <= state_nx;
      cur           <= cur_nx;
      count_latched <= count_nx;
      pages_done    <= done_nx;
      gap_cnt       <= gap_nx;
      pg_start      <= pg_start_nx;
      pg_addr       <= pg_addr_nx;
      mode_end      <= end_nx;
      mode_error    <= error_nx;
    end
  end

endmodule

// File: tb/tb_checker_auto_seq.sv
// tb_checker_auto_seq: scoreboard bench for the auto-mode page sequencer.
// A reference model predicts page issues and end/error pulses per job; a
// monitor pops and compares whenever the DUT shows one of those events.
module tb_checker_auto_seq;

  localparam int PAGE_SHIFT = 12;
  localparam int GAP_CYCLES = 1;
  localparam int EV_PAGE = 0;
  localparam int EV_END  = 1;
  localparam int EV_ERR  = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        mode_start = 1'b0;
  logic [63:0] mode_addr = 64'd0;
  logic [31:0] mode_count = 32'd0;
  logic        mode_end, mode_error, mode_irq;
  logic        mode_ack = 1'b0;
  logic [63:0] mode_data;
  logic        pg_start;
  logic [63:0] pg_addr;
  logic        pg_end = 1'b0;
  logic        pg_error = 1'b0;
  logic        pg_irq = 1'b0;
  logic        pg_ack;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          kind;
    logic [63:0] val;
  } ev_t;

  ev_t  exp_q[$];
  logic prev_start = 1'b0;

  checker_auto_seq #(.PAGE_SHIFT(PAGE_SHIFT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .mode_start(mode_start), .mode_addr(mode_addr), .mode_count(mode_count),
    .mode_end(mode_end), .mode_error(mode_error), .mode_irq(mode_irq),
    .mode_ack(mode_ack), .mode_data(mode_data),
    .pg_start(pg_start), .pg_addr(pg_addr), .pg_end(pg_end),
    .pg_error(pg_error), .pg_irq(pg_irq), .pg_ack(pg_ack)
  );

  // Free-running clock
  always #5 sys_clk = ~sys_clk;

  // Global time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h want 0x%h", name, act, req);
    end
  endtask

  function automatic void push_ev(input int kind, input logic [63:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  // Reference model: page p lives at base + p*stride; the walk ends on the
  // error page, on the last page, or when the next page would pass 2^64.
  function automatic int model_job(input logic [63:0] addr, input logic [31:0] count,
                                   input int errp, input int abortp);
    logic [64:0] stride, base, a, nxt, top;
    logic [63:0] mask;
    stride = 65'd1 << PAGE_SHIFT;
    mask   = ~((64'd1 << PAGE_SHIFT) - 64'd1);
    base   = {1'b0, addr & mask};
    top    = {1'b0, {64{1'b1}}};
    if (count == 32'd0) begin
      push_ev(EV_END, 64'd0);
      return 0;
    end
    for (int p = 0; p < int'(count); p++) begin
      a = base + 65'(p) * stride;
      push_ev(EV_PAGE, a[63:0]);
      if (p == abortp) return p + 1;
      if (p == errp) begin
        push_ev(EV_ERR, {32'(p), count});
        return p + 1;
      end
      if (p + 1 == int'(count)) begin
        push_ev(EV_END, {count, count});
        return p + 1;
      end
      nxt = base + 65'(p + 1) * stride;
      if (nxt > top) begin
        push_ev(EV_ERR, {32'(p + 1), count});
        return p + 1;
      end
    end
    return int'(count);
  endfunction

  task automatic sb_pop(input int kind, input logic [63:0] val, input string name);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: got unexpected event val=0x%h want none", name, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        bad++;
        $display("[TB] FAIL %s: got kind=%0d val=0x%h want kind=%0d val=0x%h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: page issue on pg_start rise, end/error on their pulses
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (pg_start === 1'b1 && prev_start !== 1'b1) sb_pop(EV_PAGE, pg_addr, "page_addr");
      if (mode_end === 1'b1) sb_pop(EV_END, mode_data, "end_data");
      if (mode_error === 1'b1) sb_pop(EV_ERR, mode_data, "error_data");
    end
    prev_start = pg_start;
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (pg_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    check_output("pg_start_timeout", 64'(pg_start), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge sys_clk);
    check_output("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // One job: engine model answers each page with end, error or an abort
  task automatic apply_stimulus(input logic [63:0] addr, input logic [31:0] count,
                                input int errp, input int abortp);
    int issued;
    bit ok;
    issued = model_job(addr, count, errp, abortp);
    mode_addr  = addr;
    mode_count = count;
    mode_start = 1'b1;
    for (int p = 0; p < issued; p++) begin
      wait_start(ok);
      if (!ok) begin
        exp_q.delete();
        mode_start = 1'b0;
        repeat (3) @(negedge sys_clk);
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      if (p == abortp) begin
        mode_start = 1'b0;
        pg_end = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        pg_end = 1'b0;
        check_output("abort_drop", 64'(pg_start), 64'd0);
        check_output("abort_data", mode_data, {32'(p), count});
        repeat (3) @(negedge sys_clk);
        wait_drain();
        return;
      end else if (p == errp) begin
        pg_error = 1'b1;
        pg_end = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
        pg_error = 1'b0;
        pg_end = 1'b0;
        check_output("error_drop", 64'(pg_start), 64'd0);
      end else begin
        pg_end = 1'b1;
        @(negedge sys_clk);
        pg_end = 1'b0;
        check_output("end_drop", 64'(pg_start), 64'd0);
      end
    end
    wait_drain();
    mode_start = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_pg_start"}, 64'(pg_start), 64'd0);
    check_output({tag, "_pg_addr"}, pg_addr, 64'd0);
    check_output({tag, "_mode_end"}, 64'(mode_end), 64'd0);
    check_output({tag, "_mode_error"}, 64'(mode_error), 64'd0);
    check_output({tag, "_mode_data"}, mode_data, 64'd0);
    check_output({tag, "_mode_irq"}, 64'(mode_irq), 64'd0);
    check_output({tag, "_pg_ack"}, 64'(pg_ack), 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [31:0] rc;
    int re, rb;
    bit ok;

    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);

    $display("[TB] three pages");
    apply_stimulus(64'h0000_0000_1000_0123, 32'd3, -1, -1);
    $display("[TB] error on second page");
    apply_stimulus(64'h0000_0012_3456_7890, 32'd3, 1, -1);
    $display("[TB] abort then restart");
    apply_stimulus(64'h0000_0000_2000_0000, 32'd3, -1, 1);
    apply_stimulus(64'h0000_0000_2000_0000, 32'd3, -1, -1);
    $display("[TB] zero count");
    apply_stimulus(64'h0000_0000_3000_0000, 32'd0, -1, -1);
    $display("[TB] address wrap");
    apply_stimulus(64'hFFFF_FFFF_FFFF_F000, 32'd2, -1, -1);

    $display("[TB] irq relay and reset mid-run");
    pg_irq = 1'b1;
    #1 check_output("irq_idle", 64'(mode_irq), 64'd0);
    mode_addr  = 64'h0000_0000_0004_2abc;
    mode_count = 32'd4;
    push_ev(EV_PAGE, 64'h0000_0000_0004_2000);
    mode_start = 1'b1;
    wait_start(ok);
    #1 check_output("irq_run", 64'(mode_irq), 64'd1);
    check_output("ack_low", 64'(pg_ack), 64'd0);
    mode_ack = 1'b1;
    #1 check_output("ack_run", 64'(pg_ack), 64'd1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_all_zero("midrun_reset");
    sys_rst = 1'b0;
    mode_start = 1'b0;
    pg_irq = 1'b0;
    mode_ack = 1'b0;
    wait_drain();
    repeat (2) @(negedge sys_clk);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 30; j++) begin
      ra = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) ra[63:16] = '1;
      rc = 32'($urandom_range(0, 5));
      re = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
      rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      apply_stimulus(ra, rc, re, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
